// File: rtl/rv32i_types.sv
// Shared widths and the cacheline adapter state encoding for the mp3 top level.
package rv32i_types;

    localparam int unsigned LINE_BITS = 256;
    localparam int unsigned BEAT_BITS = 64;
    localparam int unsigned BEATS     = LINE_BITS / BEAT_BITS;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_BEAT,
        WR_BEAT,
        DONE
    } adapter_state_t;

endpackage

// File: rtl/cacheline_adapter.sv
// Bridges the cache's 256-bit line port to the 64-bit burst memory: one read request
// plus four collected beats per fill, four consecutive write beats per write-back.
module cacheline_adapter
    import rv32i_types::*;
#(
    parameter int unsigned LINE_BITS = 256,
    parameter int unsigned BEAT_BITS = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          dfp_addr,
    input  logic                 dfp_read,
    input  logic                 dfp_write,
    input  logic [LINE_BITS-1:0] dfp_wdata,
    output logic [LINE_BITS-1:0] dfp_rdata,
    output logic                 dfp_resp,
    output logic [31:0]          bmem_address,
    output logic                 bmem_read,
    output logic                 bmem_write,
    output logic [BEAT_BITS-1:0] bmem_wdata,
    input  logic [BEAT_BITS-1:0] bmem_rdata,
    input  logic                 bmem_resp
);

    localparam int unsigned N_BEATS   = LINE_BITS / BEAT_BITS;
    localparam logic [1:0]  LAST_BEAT = 2'(N_BEATS - 1);

    adapter_state_t         r_state;
    logic [1:0]             r_cnt;
    logic [LINE_BITS-1:0]   r_line;
    logic [LINE_BITS-1:0]   r_rdata;
    logic [31:0]            r_addr;
    logic                   r_dfp_resp;
    logic                   r_bmem_read;
    logic                   r_bmem_write;
    logic [BEAT_BITS-1:0]   r_bmem_wdata;
    logic [1:0]             w_cnt_next;
    logic [31:0]            w_aligned;

    assign w_cnt_next = r_cnt + 2'd1;
    assign w_aligned  = {dfp_addr[31:5], 5'b0};

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_dfp_resp   <= 1'b0;
            r_bmem_read  <= 1'b0;
            r_bmem_write <= 1'b0;
            r_bmem_wdata <= '0;
        end else begin
            r_dfp_resp  <= 1'b0;
            r_bmem_read <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // Read has priority; a simultaneous write is dropped.
                    if (dfp_read) begin
                        r_addr      <= w_aligned;
                        r_bmem_read <= 1'b1;
                        r_state     <= RD_REQ;
                    end else if (dfp_write) begin
                        r_addr       <= w_aligned;
                        r_line       <= dfp_wdata;
                        r_bmem_write <= 1'b1;
                        r_bmem_wdata <= dfp_wdata[BEAT_BITS-1:0];
                        r_cnt        <= '0;
                        r_state      <= WR_BEAT;
                    end
                end
                RD_REQ: begin
                    r_cnt   <= '0;
                    r_state <= RD_BEAT;
                end
                RD_BEAT: begin
                    if (bmem_resp) begin
                        r_rdata[r_cnt*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
                        r_cnt <= w_cnt_next;
                        if (r_cnt == LAST_BEAT) begin
                            r_dfp_resp <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                WR_BEAT: begin
                    // Next beat's data is staged so it is on the bus with the next write strobe.
                    if (r_cnt == LAST_BEAT) begin
                        r_bmem_write <= 1'b0;
                        r_dfp_resp   <= 1'b1;
                        r_state      <= DONE;
                    end else begin
                        r_cnt        <= w_cnt_next;
                        r_bmem_wdata <= r_line[w_cnt_next*BEAT_BITS +: BEAT_BITS];
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign dfp_rdata    = r_rdata;
    assign dfp_resp     = r_dfp_resp;
    assign bmem_address = r_addr;
    assign bmem_read    = r_bmem_read;
    assign bmem_write   = r_bmem_write;
    assign bmem_wdata   = r_bmem_wdata;

endmodule
